// File: rtl/ofifo_accum_drain.sv
// Output-FIFO drain and multi-pass accumulator for the systolic array.
// Reads one partial-sum vector per FIFO read, accumulates it into a row
// buffer over several passes, then streams the finished rows out with
// optional ReLU through a valid/ready handshake.
module ofifo_accum_drain #(
  parameter int col     = 8,
  parameter int bw      = 16,
  parameter int psum_bw = 16,
  parameter int depth   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [$clog2(depth)-1:0]   cfg_rows,
  input  logic [3:0]                 cfg_passes,
  input  logic                       relu_en,
  input  logic                       ofifo_valid,
  output logic                       ofifo_rd,
  input  logic [col*bw-1:0]          ofifo_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [col*psum_bw-1:0]     out_data,
  output logic [$clog2(depth)-1:0]   out_row,
  output logic                       busy,
  output logic                       done
);

  localparam int RW = $clog2(depth);
  localparam logic [RW-1:0] ROW_ONE  = 1;
  localparam logic [RW:0]   CNT_ONE  = 1;
  localparam logic [3:0]    PASS_ONE = 1;

  typedef enum logic [1:0] {IDLE, DRAIN, OUTPUT} state_t;

  state_t               state, state_nxt;
  logic [RW-1:0]        rows_q;
  logic [3:0]           passes_q;
  logic                 relu_q;
  logic [RW-1:0]        row;
  logic [3:0]           pass;
  logic [RW:0]          rd_cnt;     // reads issued in the current pass
  logic                 rd_q;       // a read was issued last cycle; its data is on ofifo_out now
  logic signed [psum_bw-1:0] acc      [depth][col];
  logic signed [psum_bw-1:0] lane_ext [col];
  logic                 capture;
  logic                 last_row;

  assign capture  = (state == DRAIN) && rd_q;
  assign last_row = (row == rows_q);

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic; DRAIN only leaves on the capture of the last row of the last pass
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = DRAIN;
      DRAIN:   if (capture && last_row && (pass == passes_q)) state_nxt = OUTPUT;
      OUTPUT:  if (out_ready && last_row) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs; reads are never back-to-back so the FIFO flag is always fresh
  always_comb begin
    ofifo_rd  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      DRAIN: begin
        busy     = 1'b1;
        ofifo_rd = ofifo_valid && !rd_q && (rd_cnt <= {1'b0, rows_q});
      end
      OUTPUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        done      = out_ready && last_row;
      end
      default: ;
    endcase
  end

  // job configuration, row/pass counters and read tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rows_q   <= '0;
      passes_q <= '0;
      relu_q   <= 1'b0;
      row      <= '0;
      pass     <= '0;
      rd_cnt   <= '0;
      rd_q     <= 1'b0;
    end else begin
      rd_q <= ofifo_rd;
      unique case (state)
        IDLE: begin
          if (start) begin
            rows_q   <= cfg_rows;
            passes_q <= cfg_passes;
            relu_q   <= relu_en;
            row      <= '0;
            pass     <= '0;
            rd_cnt   <= '0;
          end
        end
        DRAIN: begin
          if (ofifo_rd) rd_cnt <= rd_cnt + CNT_ONE;
          if (capture) begin
            if (last_row) begin
              row    <= '0;
              rd_cnt <= '0;
              if (pass != passes_q) pass <= pass + PASS_ONE;
            end else begin
              row <= row + ROW_ONE;
            end
          end
        end
        OUTPUT: begin
          if (out_ready) row <= last_row ? '0 : row + ROW_ONE;
        end
        default: ;
      endcase
    end
  end

  // sign-extend or truncate each FIFO lane to the accumulator width
  always_comb begin
    for (int unsigned i = 0; i < col; i++)
      lane_ext[i] = psum_bw'(signed'(ofifo_out[i*bw +: bw]));
  end

  // accumulate the captured vector into the current row (pass 0 overwrites)
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int unsigned i = 0; i < col; i++)
        acc[row][i] <= (pass == '0) ? lane_ext[i] : acc[row][i] + lane_ext[i];
    end
  end

  // output row view with optional ReLU; held stable by the unchanged row index while stalled
  always_comb begin
    out_data = '0;
    out_row  = '0;
    if (state == OUTPUT) begin
      out_row = row;
      for (int unsigned i = 0; i < col; i++)
        out_data[i*psum_bw +: psum_bw] = (relu_q && acc[row][i][psum_bw-1]) ? '0 : acc[row][i];
    end
  end

endmodule
